pipe_ctrl_unit: RTL and testbench
=================================

# pipe_ctrl_unit

Pipelined MIPS control unit with integrated hazard handling. Decodes the instruction in ID and carries the control bundle through its own ID/EX, EX/MEM and MEM/WB control registers. It detects load-use and branch-operand hazards, sequences a multi-cycle multiply with a stall counter, and drives PC/IF-ID write enables, flush and PC select. It sits beside the pipeline datapath and takes register addresses and the ID-stage comparator result from it.

## Interface
- `MUL_LATENCY`, 4: number of cycles a `mult` occupies EX; must be ≥1.
- `REG_AW`, 5: register-address width.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 6: ID-stage instruction opcode.
- `func` in 6: ID-stage function field.
- `id_rs`, `id_rt` in REG_AW: source registers of the ID-stage instruction.
- `ex_dst_reg`, `mem_dst_reg` in REG_AW: destination registers from the datapath EX and MEM stages.
- `operands_equal` in 1: ID-stage comparator result.
- `pc_write`, `ifid_write` out 1: PC and IF/ID enables.
- `if_flush` out 1: turns IF/ID into a nop.
- `pc_src` out 2: 00 PC+4, 01 branch target, 10 jump target, 11 rs.
- `ex_reg_dst` out 2, `ex_alu_src` out 1, `ex_operation` out 3: EX controls.
- `mem_read`, `mem_write` out 1: MEM controls.
- `wb_reg_write` out 1, `wb_mem_to_reg` out 2: WB controls.
- `mul_busy` out 1: multiply in progress.
- `illegal_op` out 1: one-cycle pulse.

## Operation
- Decoded instructions:
  - R-type (000000): add 100000, sub 100010, and 100100, or 100101, slt 101010, mult 011000.
  - lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, slti 001010, j 000010, jal 000011, jr 000110.
- Any other opcode, or any R-type func not in the list above, decodes to an all-zero bundle and raises `illegal_op` one cycle later.
- ALU operation encoding: and 000, or 001, add 010, mul 011, sub 110, slt 111. lw, sw and addi use add; slti uses slt.
- Destination selection:
  - `reg_dst`: 00 rt, 01 rd, 10 $31.
  - `mem_to_reg`: 00 ALU, 01 memory, 10 PC+4.
  - jal writes $31 with PC+4.
- Source usage:
  - rs is used by every instruction except j and jal.
  - rt is used by R-type, sw, beq and bne.
- Load-use hazard: `mem_read`(EX) & `ex_dst_reg`≠0 & `ex_dst_reg` equals a used source.
- Branch hazard (beq, bne, jr in ID): either condition below, with the matching register ≠0:
  - EX reg_write & `ex_dst_reg` matches a used source;
  - MEM mem_read & `mem_dst_reg` matches a used source.
- Hazard stall: `pc_write`=`ifid_write`=0, ID/EX loads a bubble, `pc_src`=00, `if_flush`=0.
- Redirect (no stall):
  - beq taken when `operands_equal`=1; bne taken when `operands_equal`=0.
  - Taken branch, j, jal and jr set `pc_src` accordingly and assert `if_flush`=1.
  - A not-taken branch gives `pc_src`=00 and `if_flush`=0.
- Multiply FSM, states IDLE and BUSY:
  - IDLE→BUSY when `mult` is in EX and MUL_LATENCY>1; the counter loads MUL_LATENCY-1.
  - In BUSY: the counter decrements each cycle; PC, IF/ID and ID/EX hold; EX/MEM loads a bubble; `mul_busy`=1.
  - BUSY→IDLE when the counter reaches 1; the mult advances to MEM on the following edge.
  - With MUL_LATENCY=1 the unit never enters BUSY.
- Priority: multiply stall > hazard stall > redirect > normal.
- Bubble: all register and memory write enables zero and `operation`=000.

## Timing
- Decode and hazard logic are combinational in ID.
- Control registers advance on the rising edge: ID→EX, EX→MEM and MEM→WB, one cycle each.
- `pc_write`, `ifid_write`, `if_flush` and `pc_src` are combinational from the ID-stage inputs and state.
- `illegal_op` is registered and pulses for exactly one cycle per offending instruction that enters EX.
- Reset, asynchronous:
  - All control registers clear to bubble.
  - FSM goes to IDLE; counter=0; `illegal_op`=0.
  - While `rst`=1, every output is 0, including `pc_write` and `ifid_write`.
- Reset asserted mid-multiply aborts the multiply; after release the unit is in IDLE with an empty pipe.
- A load-use condition during BUSY is re-evaluated after BUSY ends; no double bubble is inserted.

## Structure
- `ctrl_pkg`:
  - opcode and func localparams, ALU operation codes, `pc_src`/`reg_dst`/`mem_to_reg` encodings;
  - packed `ctrl_t` struct (reg_dst, mem_to_reg, reg_write, alu_src, mem_read, mem_write, operation) and a `CTRL_BUBBLE` constant.
- Sub-module `alu_op_decode`: combinational map from opcode and func to `operation` and the illegal flag.
- Hazard logic, the three control registers and the multiply FSM live in the top module.

## Test plan
- Reset: `rst` pulsed mid-stream → all outputs 0 immediately; after release the first add reaches `wb_reg_write`=1 three cycles after leaving ID.
- Load-use: lw $2 followed by add $3,$2,$4 → exactly one cycle with `pc_write`=0 and a bubble in EX; lw to $0 → no stall.
- Branch: beq with `operands_equal`=1 → `pc_src`=01, `if_flush`=1; bne with equal=1 → `pc_src`=00, no flush; beq after lw to its rs → two stall cycles, then resolves.
- Jumps: j → `pc_src`=10 with flush; jal → `pc_src`=10, `ex_reg_dst`=10, `wb_mem_to_reg`=10; jr → `pc_src`=11 with flush.
- Multiply at MUL_LATENCY=4: mult in EX → `mul_busy`=1 for 3 cycles, front end frozen, 3 bubbles into MEM, then `operation`=011 reaches MEM; at MUL_LATENCY=1 → no stall.
- Illegal: opcode 111111 → bubble bundle and a single `illegal_op` pulse.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the pipelined MIPS control unit.
//   - opcode / func field values of the decoded instruction subset
//   - ALU operation codes, pc_src / reg_dst / mem_to_reg encodings
//   - ctrl_t: the control bundle carried through ID/EX, EX/MEM, MEM/WB
//   - CTRL_BUBBLE: the all-zero bundle (no writes, operation 000)
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_JR    = 6'b000110;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_MULT = 6'b011000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] operation;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational opcode/func -> ALU operation map.
//   opcode, func : ID-stage instruction fields
//   operation    : ALU operation code (000 for anything illegal)
//   illegal      : instruction is outside the decoded subset
module alu_op_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output logic [2:0] operation,
  output logic       illegal
);

  always_comb begin
    operation = ALU_AND;
    illegal   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_ADD:  operation = ALU_ADD;
          FN_SUB:  operation = ALU_SUB;
          FN_AND:  operation = ALU_AND;
          FN_OR:   operation = ALU_OR;
          FN_SLT:  operation = ALU_SLT;
          FN_MULT: operation = ALU_MUL;
          default: illegal   = 1'b1;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI: operation = ALU_ADD;
      OP_BEQ, OP_BNE:        operation = ALU_SUB;
      OP_SLTI:               operation = ALU_SLT;
      OP_J, OP_JAL, OP_JR:   operation = ALU_AND;
      default:               illegal   = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipelined MIPS control unit with hazard handling.
//   Decodes the ID-stage instruction, carries its control bundle through
//   ID/EX, EX/MEM and MEM/WB, detects load-use and branch-operand hazards,
//   sequences a multi-cycle mult and drives the front-end enables.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   opcode, func             : ID-stage instruction fields
//   id_rs, id_rt             : ID-stage source registers
//   ex_dst_reg, mem_dst_reg  : datapath destination registers in EX / MEM
//   operands_equal           : ID-stage register comparator
//   pc_write, ifid_write     : front-end enables (0 while stalled or in reset)
//   if_flush, pc_src         : redirect controls
//   ex_reg_dst, ex_alu_src, ex_operation : EX controls
//   mem_read, mem_write      : MEM controls
//   wb_reg_write, wb_mem_to_reg : WB controls
//   mul_busy                 : multiply sequencer is in BUSY
//   illegal_op               : one-cycle pulse while an illegal instruction is in EX
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int REG_AW      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        opcode,
  input  logic [5:0]        func,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] ex_dst_reg,
  input  logic [REG_AW-1:0] mem_dst_reg,
  input  logic              operands_equal,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              if_flush,
  output logic [1:0]        pc_src,
  output logic [1:0]        ex_reg_dst,
  output logic              ex_alu_src,
  output logic [2:0]        ex_operation,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_reg_write,
  output logic [1:0]        wb_mem_to_reg,
  output logic              mul_busy,
  output logic              illegal_op
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int              CNT_W     = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
  localparam bit              MUL_MULTI = (MUL_LATENCY > 1);

  ctrl_t             id_ctrl;
  logic [2:0]        id_op;
  logic              id_illegal;
  logic              uses_rs, uses_rt;
  logic              is_beq, is_bne, is_j, is_jal, is_jr;

  ctrl_t             ex_ctrl_p0, mem_ctrl_p1, wb_ctrl_p2;
  logic              ex_ill_p0;

  logic [0:0]        mul_state;
  logic [CNT_W-1:0]  mul_cnt;
  logic              mul_stall;

  logic              ex_match, mem_match, load_use, branch_haz, hazard_stall;
  logic              redirect;
  logic [1:0]        redirect_src;
  logic              stall_any;

  alu_op_decode u_alu_op_decode (
    .opcode    (opcode),
    .func      (func),
    .operation (id_op),
    .illegal   (id_illegal)
  );

  // ID: main decode
  always_comb begin
    id_ctrl = CTRL_BUBBLE;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    is_jal  = 1'b0;
    is_jr   = 1'b0;
    if (!id_illegal) begin
      id_ctrl.operation = id_op;
      case (opcode)
        OP_RTYPE: begin
          id_ctrl.reg_dst   = RD_RD;
          id_ctrl.reg_write = 1'b1;
          uses_rs = 1'b1;
          uses_rt = 1'b1;
        end
        OP_LW: begin
          id_ctrl.reg_dst    = RD_RT;
          id_ctrl.mem_to_reg = WB_MEM;
          id_ctrl.reg_write  = 1'b1;
          id_ctrl.alu_src    = 1'b1;
          id_ctrl.mem_read   = 1'b1;
          uses_rs = 1'b1;
        end
        OP_SW: begin
          id_ctrl.alu_src   = 1'b1;
          id_ctrl.mem_write = 1'b1;
          uses_rs = 1'b1;
          uses_rt = 1'b1;
        end
        OP_BEQ: begin
          is_beq  = 1'b1;
          uses_rs = 1'b1;
          uses_rt = 1'b1;
        end
        OP_BNE: begin
          is_bne  = 1'b1;
          uses_rs = 1'b1;
          uses_rt = 1'b1;
        end
        OP_ADDI, OP_SLTI: begin
          id_ctrl.reg_dst   = RD_RT;
          id_ctrl.reg_write = 1'b1;
          id_ctrl.alu_src   = 1'b1;
          uses_rs = 1'b1;
        end
        OP_J: is_j = 1'b1;
        OP_JAL: begin
          is_jal = 1'b1;
          id_ctrl.reg_dst    = RD_RA;
          id_ctrl.mem_to_reg = WB_PC4;
          id_ctrl.reg_write  = 1'b1;
        end
        OP_JR: begin
          is_jr   = 1'b1;
          uses_rs = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ID: hazard detection and redirect; branches resolve here, so their
  // operands must not still be in flight from an EX writer or a MEM load.
  always_comb begin
    ex_match  = (uses_rs && (ex_dst_reg == id_rs)) || (uses_rt && (ex_dst_reg == id_rt));
    mem_match = (uses_rs && (mem_dst_reg == id_rs)) || (uses_rt && (mem_dst_reg == id_rt));
    load_use  = ex_ctrl_p0.mem_read && (ex_dst_reg != '0) && ex_match;
    branch_haz = (is_beq || is_bne || is_jr) &&
                 ((ex_ctrl_p0.reg_write && (ex_dst_reg != '0) && ex_match) ||
                  (mem_ctrl_p1.mem_read && (mem_dst_reg != '0) && mem_match));
    hazard_stall = load_use || branch_haz;

    redirect     = 1'b0;
    redirect_src = PC_SEQ;
    if ((is_beq && operands_equal) || (is_bne && !operands_equal)) begin
      redirect     = 1'b1;
      redirect_src = PC_BRANCH;
    end else if (is_j || is_jal) begin
      redirect     = 1'b1;
      redirect_src = PC_JUMP;
    end else if (is_jr) begin
      redirect     = 1'b1;
      redirect_src = PC_REG;
    end
  end

  // The mult is held in EX for its first cycle (IDLE) and every BUSY cycle
  // except the last one, so it occupies EX for exactly MUL_LATENCY cycles.
  always_comb begin
    mul_stall = 1'b0;
    if (MUL_MULTI) begin
      if (mul_state == ST_IDLE)
        mul_stall = (ex_ctrl_p0.operation == ALU_MUL);
      else
        mul_stall = (mul_cnt != CNT_LAST);
    end
  end

  assign stall_any  = mul_stall || hazard_stall;
  assign pc_write   = !rst && !stall_any;
  assign ifid_write = !rst && !stall_any;
  assign if_flush   = !rst && !stall_any && redirect;
  assign pc_src     = (rst || stall_any) ? PC_SEQ : redirect_src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_state <= ST_IDLE;
      mul_cnt   <= '0;
    end else begin
      case (mul_state)
        ST_IDLE: begin
          if (MUL_MULTI && (ex_ctrl_p0.operation == ALU_MUL)) begin
            mul_state <= ST_BUSY;
            mul_cnt   <= CNT_LOAD;
          end
        end
        default: begin
          mul_cnt <= mul_cnt - CNT_LAST;
          if (mul_cnt == CNT_LAST)
            mul_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ctrl_p0  <= CTRL_BUBBLE;
      ex_ill_p0   <= 1'b0;
      mem_ctrl_p1 <= CTRL_BUBBLE;
      wb_ctrl_p2  <= CTRL_BUBBLE;
    end else begin
      // ID -> EX
      if (!mul_stall) begin
        if (hazard_stall) begin
          ex_ctrl_p0 <= CTRL_BUBBLE;
          ex_ill_p0  <= 1'b0;
        end else begin
          ex_ctrl_p0 <= id_ctrl;
          ex_ill_p0  <= id_illegal;
        end
      end
      // EX -> MEM
      mem_ctrl_p1 <= mul_stall ? CTRL_BUBBLE : ex_ctrl_p0;
      // MEM -> WB
      wb_ctrl_p2  <= mem_ctrl_p1;
    end
  end

  assign ex_reg_dst    = ex_ctrl_p0.reg_dst;
  assign ex_alu_src    = ex_ctrl_p0.alu_src;
  assign ex_operation  = ex_ctrl_p0.operation;
  assign mem_read      = mem_ctrl_p1.mem_read;
  assign mem_write     = mem_ctrl_p1.mem_write;
  assign wb_reg_write  = wb_ctrl_p2.reg_write;
  assign wb_mem_to_reg = wb_ctrl_p2.mem_to_reg;
  assign mul_busy      = (mul_state == ST_BUSY);
  assign illegal_op    = ex_ill_p0;

  // WB only consumes the write-back fields of the bundle.
  logic wb_unused;
  assign wb_unused = ^{wb_ctrl_p2.reg_dst, wb_ctrl_p2.alu_src, wb_ctrl_p2.mem_read,
                       wb_ctrl_p2.mem_write, wb_ctrl_p2.operation};

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: directed bench for pipe_ctrl_unit (MUL_LATENCY 4 and 1).
module tb_pipe_ctrl_unit;

  localparam logic [5:0] O_R    = 6'b000000;
  localparam logic [5:0] O_LW   = 6'b100011;
  localparam logic [5:0] O_BEQ  = 6'b000100;
  localparam logic [5:0] O_BNE  = 6'b000101;
  localparam logic [5:0] O_J    = 6'b000010;
  localparam logic [5:0] O_JAL  = 6'b000011;
  localparam logic [5:0] O_JR   = 6'b000110;
  localparam logic [5:0] O_BAD  = 6'b111111;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_BAD  = 6'b000111;
  localparam logic [5:0] F_NONE = 6'b000000;

  logic       clk, rst;
  logic [5:0] opcode, func;
  logic [4:0] id_rs, id_rt, ex_dst_reg, mem_dst_reg;
  logic       operands_equal;

  logic       pc_write, ifid_write, if_flush, ex_alu_src, mem_read, mem_write;
  logic       wb_reg_write, mul_busy, illegal_op;
  logic [1:0] pc_src, ex_reg_dst, wb_mem_to_reg;
  logic [2:0] ex_operation;

  logic       pc_write_1, ifid_write_1, if_flush_1, ex_alu_src_1, mem_read_1, mem_write_1;
  logic       wb_reg_write_1, mul_busy_1, illegal_op_1;
  logic [1:0] pc_src_1, ex_reg_dst_1, wb_mem_to_reg_1;
  logic [2:0] ex_operation_1;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_ctrl_unit #(.MUL_LATENCY(4), .REG_AW(5)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func),
    .id_rs(id_rs), .id_rt(id_rt), .ex_dst_reg(ex_dst_reg), .mem_dst_reg(mem_dst_reg),
    .operands_equal(operands_equal),
    .pc_write(pc_write), .ifid_write(ifid_write), .if_flush(if_flush), .pc_src(pc_src),
    .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_operation(ex_operation),
    .mem_read(mem_read), .mem_write(mem_write),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .mul_busy(mul_busy), .illegal_op(illegal_op)
  );

  pipe_ctrl_unit #(.MUL_LATENCY(1), .REG_AW(5)) u_dut1 (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func),
    .id_rs(id_rs), .id_rt(id_rt), .ex_dst_reg(ex_dst_reg), .mem_dst_reg(mem_dst_reg),
    .operands_equal(operands_equal),
    .pc_write(pc_write_1), .ifid_write(ifid_write_1), .if_flush(if_flush_1), .pc_src(pc_src_1),
    .ex_reg_dst(ex_reg_dst_1), .ex_alu_src(ex_alu_src_1), .ex_operation(ex_operation_1),
    .mem_read(mem_read_1), .mem_write(mem_write_1),
    .wb_reg_write(wb_reg_write_1), .wb_mem_to_reg(wb_mem_to_reg_1),
    .mul_busy(mul_busy_1), .illegal_op(illegal_op_1)
  );

  logic d1_unused;
  assign d1_unused = ^{ifid_write_1, if_flush_1, ex_alu_src_1, mem_read_1, mem_write_1,
                       illegal_op_1, pc_src_1, ex_reg_dst_1, wb_mem_to_reg_1, mem_write};

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic id_in(input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt);
    opcode = op;
    func   = fn;
    id_rs  = rs;
    id_rt  = rt;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    opcode = O_BEQ; func = F_NONE; id_rs = '0; id_rt = '0;
    ex_dst_reg = '0; mem_dst_reg = '0; operands_equal = 1'b0;
    #3;
    // reset state
    chk("rst_pc_write",   32'(pc_write),     32'd0);
    chk("rst_ifid_write", 32'(ifid_write),   32'd0);
    chk("rst_pc_src",     32'(pc_src),       32'd0);
    chk("rst_if_flush",   32'(if_flush),     32'd0);
    chk("rst_ex_op",      32'(ex_operation), 32'd0);
    chk("rst_mem_read",   32'(mem_read),     32'd0);
    chk("rst_wb_write",   32'(wb_reg_write), 32'd0);
    chk("rst_illegal",    32'(illegal_op),   32'd0);
    chk("rst_mul_busy",   32'(mul_busy),     32'd0);

    // add $3,$1,$2 travels to WB
    tick;
    rst = 1'b0;
    id_in(O_R, F_ADD, 5'd1, 5'd2);
    chk("add_pc_write", 32'(pc_write), 32'd1);
    tick;
    ex_dst_reg = 5'd3;
    id_in(O_BEQ, F_NONE, 5'd0, 5'd0);
    chk("add_ex_reg_dst", 32'(ex_reg_dst),   32'd1);
    chk("add_ex_op",      32'(ex_operation), 32'd2);
    chk("add_ex_alu_src", 32'(ex_alu_src),   32'd0);
    tick;
    ex_dst_reg = 5'd0; mem_dst_reg = 5'd3;
    #1;
    chk("add_wb_early", 32'(wb_reg_write), 32'd0);
    tick;
    mem_dst_reg = 5'd0;
    #1;
    chk("add_wb_write", 32'(wb_reg_write),  32'd1);
    chk("add_wb_m2r",   32'(wb_mem_to_reg), 32'd0);

    // load-use: lw $2 then add $3,$2,$4
    id_in(O_LW, F_NONE, 5'd1, 5'd2);
    chk("lw_pc_write", 32'(pc_write), 32'd1);
    tick;
    ex_dst_reg = 5'd2;
    id_in(O_R, F_ADD, 5'd2, 5'd4);
    chk("lu_pc_write",   32'(pc_write),     32'd0);
    chk("lu_ifid_write", 32'(ifid_write),   32'd0);
    chk("lu_pc_src",     32'(pc_src),       32'd0);
    chk("lu_if_flush",   32'(if_flush),     32'd0);
    chk("lu_lw_ex_op",   32'(ex_operation), 32'd2);
    chk("lu_lw_alu_src", 32'(ex_alu_src),   32'd1);
    tick;
    ex_dst_reg = 5'd0; mem_dst_reg = 5'd2;
    #1;
    chk("lu_bubble_op",   32'(ex_operation), 32'd0);
    chk("lu_bubble_rd",   32'(ex_reg_dst),   32'd0);
    chk("lu_mem_read",    32'(mem_read),     32'd1);
    chk("lu_release_pcw", 32'(pc_write),     32'd1);
    tick;
    ex_dst_reg = 5'd3; mem_dst_reg = 5'd0;
    #1;
    chk("lu_add_ex_op", 32'(ex_operation),  32'd2);
    chk("lu_add_rd",    32'(ex_reg_dst),    32'd1);
    chk("lu_lw_wb_m2r", 32'(wb_mem_to_reg), 32'd1);
    chk("lu_lw_wb_wr",  32'(wb_reg_write),  32'd1);

    // lw to $0 never stalls
    id_in(O_LW, F_NONE, 5'd1, 5'd0);
    chk("lw0_pc_write", 32'(pc_write), 32'd1);
    tick;
    ex_dst_reg = 5'd0; mem_dst_reg = 5'd3;
    id_in(O_R, F_ADD, 5'd0, 5'd0);
    chk("lw0_nostall", 32'(pc_write), 32'd1);
    tick;
    ex_dst_reg = 5'd3; mem_dst_reg = 5'd0;

    // redirects, EX holds add $3 (writer), MEM holds lw $0
    operands_equal = 1'b1;
    id_in(O_BEQ, F_NONE, 5'd5, 5'd6);
    chk("beq_t_pc_src", 32'(pc_src),   32'd1);
    chk("beq_t_flush",  32'(if_flush), 32'd1);
    chk("beq_t_pcw",    32'(pc_write), 32'd1);
    id_in(O_BNE, F_NONE, 5'd5, 5'd6);
    chk("bne_nt_pc_src", 32'(pc_src),   32'd0);
    chk("bne_nt_flush",  32'(if_flush), 32'd0);
    operands_equal = 1'b0;
    id_in(O_BNE, F_NONE, 5'd5, 5'd6);
    chk("bne_t_pc_src", 32'(pc_src),   32'd1);
    chk("bne_t_flush",  32'(if_flush), 32'd1);
    id_in(O_J, F_NONE, 5'd0, 5'd0);
    chk("j_pc_src", 32'(pc_src),   32'd2);
    chk("j_flush",  32'(if_flush), 32'd1);
    id_in(O_JR, F_NONE, 5'd7, 5'd0);
    chk("jr_pc_src", 32'(pc_src),   32'd3);
    chk("jr_flush",  32'(if_flush), 32'd1);
    id_in(O_JR, F_NONE, 5'd3, 5'd0);
    chk("jr_haz_pcw",    32'(pc_write), 32'd0);
    chk("jr_haz_pc_src", 32'(pc_src),   32'd0);
    chk("jr_haz_flush",  32'(if_flush), 32'd0);
    id_in(O_JAL, F_NONE, 5'd0, 5'd0);
    chk("jal_pc_src", 32'(pc_src),   32'd2);
    chk("jal_flush",  32'(if_flush), 32'd1);
    tick;
    ex_dst_reg = 5'd31; mem_dst_reg = 5'd0;
    id_in(O_BEQ, F_NONE, 5'd0, 5'd0);
    chk("jal_ex_reg_dst", 32'(ex_reg_dst), 32'd2);
    tick;
    ex_dst_reg = 5'd0; mem_dst_reg = 5'd31;
    tick;
    mem_dst_reg = 5'd0;
    #1;
    chk("jal_wb_m2r", 32'(wb_mem_to_reg), 32'd2);
    chk("jal_wb_wr",  32'(wb_reg_write),  32'd1);

    // beq after lw to its rs: two stalls, then resolves
    id_in(O_LW, F_NONE, 5'd1, 5'd8);
    tick;
    ex_dst_reg = 5'd8; operands_equal = 1'b1;
    id_in(O_BEQ, F_NONE, 5'd8, 5'd9);
    chk("bl_s1_pcw",    32'(pc_write), 32'd0);
    chk("bl_s1_pc_src", 32'(pc_src),   32'd0);
    chk("bl_s1_flush",  32'(if_flush), 32'd0);
    tick;
    ex_dst_reg = 5'd0; mem_dst_reg = 5'd8;
    #1;
    chk("bl_s2_pcw",  32'(pc_write),     32'd0);
    chk("bl_s2_ifid", 32'(ifid_write),   32'd0);
    chk("bl_s2_ex_op", 32'(ex_operation), 32'd0);
    tick;
    mem_dst_reg = 5'd0;
    #1;
    chk("bl_go_pcw",    32'(pc_write), 32'd1);
    chk("bl_go_pc_src", 32'(pc_src),   32'd1);
    chk("bl_go_flush",  32'(if_flush), 32'd1);
    tick;

    // multiply: LATENCY 4 on u_dut, LATENCY 1 on u_dut1
    operands_equal = 1'b0;
    id_in(O_R, F_MULT, 5'd10, 5'd11);
    chk("mul_id_pcw", 32'(pc_write), 32'd1);
    tick;
    id_in(O_BEQ, F_NONE, 5'd0, 5'd0);
    chk("mul_c0_ex_op", 32'(ex_operation), 32'd3);
    chk("mul_c0_pcw",   32'(pc_write),     32'd0);
    chk("mul_c0_busy",  32'(mul_busy),     32'd0);
    chk("mul1_c0_pcw",  32'(pc_write_1),   32'd1);
    tick;
    chk("mul_c1_busy",   32'(mul_busy),       32'd1);
    chk("mul_c1_pcw",    32'(pc_write),       32'd0);
    chk("mul_c1_ifid",   32'(ifid_write),     32'd0);
    chk("mul_c1_ex_op",  32'(ex_operation),   32'd3);
    chk("mul1_c1_busy",  32'(mul_busy_1),     32'd0);
    chk("mul1_c1_ex_op", 32'(ex_operation_1), 32'd6);
    tick;
    chk("mul_c2_busy", 32'(mul_busy),       32'd1);
    chk("mul_c2_pcw",  32'(pc_write),       32'd0);
    chk("mul_c2_wb",   32'(wb_reg_write),   32'd0);
    chk("mul1_c2_wb",  32'(wb_reg_write_1), 32'd1);
    tick;
    chk("mul_c3_busy",  32'(mul_busy),     32'd1);
    chk("mul_c3_pcw",   32'(pc_write),     32'd1);
    chk("mul_c3_ex_op", 32'(ex_operation), 32'd3);
    chk("mul_c3_wb",    32'(wb_reg_write), 32'd0);
    tick;
    chk("mul_c4_busy",  32'(mul_busy),     32'd0);
    chk("mul_c4_ex_op", 32'(ex_operation), 32'd6);
    chk("mul_c4_wb",    32'(wb_reg_write), 32'd0);
    tick;
    chk("mul_c5_wb", 32'(wb_reg_write), 32'd1);

    // reset asserted mid-multiply
    id_in(O_R, F_MULT, 5'd10, 5'd11);
    tick;
    id_in(O_BEQ, F_NONE, 5'd0, 5'd0);
    tick;
    chk("mr_busy_before", 32'(mul_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_busy",  32'(mul_busy),     32'd0);
    chk("mr_pcw",   32'(pc_write),     32'd0);
    chk("mr_ifid",  32'(ifid_write),   32'd0);
    chk("mr_ex_op", 32'(ex_operation), 32'd0);
    tick;
    rst = 1'b0;
    id_in(O_R, F_ADD, 5'd1, 5'd2);
    chk("mr_rel_busy",  32'(mul_busy),     32'd0);
    chk("mr_rel_pcw",   32'(pc_write),     32'd1);
    chk("mr_rel_ex_op", 32'(ex_operation), 32'd0);
    tick;
    chk("mr_add_ex_op", 32'(ex_operation), 32'd2);
    chk("mr_add_busy",  32'(mul_busy),     32'd0);

    // illegal opcode and illegal R-type func
    id_in(O_BAD, F_NONE, 5'd0, 5'd0);
    chk("ill_pcw", 32'(pc_write), 32'd1);
    tick;
    id_in(O_BEQ, F_NONE, 5'd0, 5'd0);
    chk("ill_pulse",   32'(illegal_op),   32'd1);
    chk("ill_ex_op",   32'(ex_operation), 32'd0);
    chk("ill_ex_rd",   32'(ex_reg_dst),   32'd0);
    chk("ill_alu_src", 32'(ex_alu_src),   32'd0);
    tick;
    chk("ill_drop", 32'(illegal_op), 32'd0);
    id_in(O_R, F_BAD, 5'd1, 5'd2);
    tick;
    id_in(O_BEQ, F_NONE, 5'd0, 5'd0);
    chk("illf_pulse", 32'(illegal_op),   32'd1);
    chk("illf_ex_op", 32'(ex_operation), 32'd0);
    tick;
    chk("illf_drop", 32'(illegal_op), 32'd0);
    tick;
    chk("ill_wb_wr", 32'(wb_reg_write), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
